// File: rtl/bus_stream_fifo_if.sv
// Register bus plus TX/RX word streams for bus_stream_fifo.
// The slave modport is the FIFO block's view; master is the bus/stream driver side.
interface bus_stream_fifo_if;
    logic [15:0] baddr;
    logic [15:0] bwrdata;
    logic        bwr;
    logic        bstrobe;
    logic [15:0] brddata;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport slave (
        input  baddr, bwrdata, bwr, bstrobe,
        output brddata,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready
    );

    modport master (
        output baddr, bwrdata, bwr, bstrobe,
        input  brddata,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready
    );
endinterface

// File: rtl/bus_stream_fifo.sv
// Register-bus slave bridging bus writes to a TX word stream and an RX word stream to bus reads,
// each through a first-word-fall-through FIFO of depth 2**DEPTH_LOG2.
module bus_stream_fifo #(
    parameter logic [15:0] BASE_ADDR  = 16'h0040,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              aresetn,
    bus_stream_fifo_if.slave  bus
);
    localparam int PW = DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(1 << DEPTH_LOG2);

    logic [15:0]   w_offset;
    logic          w_inRange;
    logic          w_wrStb, w_rdStb;
    logic          w_wrCtrl, w_wrTx, w_wrFlags, w_rdRx;

    logic          r_enable, r_txOvf, r_rxUnf;

    logic [15:0]   r_txMem [1 << DEPTH_LOG2];
    logic [PW-1:0] r_txWp, r_txRp;
    logic [CW-1:0] r_txCount;
    logic          w_txEmpty, w_txFull, w_txPush, w_txPop, w_txFlush;

    logic [15:0]   r_rxMem [1 << DEPTH_LOG2];
    logic [PW-1:0] r_rxWp, r_rxRp;
    logic [CW-1:0] r_rxCount;
    logic          w_rxEmpty, w_rxFull, w_rxPush, w_rxPop, w_rxFlush;

    // Wrapping subtraction makes addresses below BASE_ADDR land out of range too.
    assign w_offset  = bus.baddr - BASE_ADDR;
    assign w_inRange = (w_offset < 16'd5);
    assign w_wrStb   = bus.bstrobe &  bus.bwr & w_inRange;
    assign w_rdStb   = bus.bstrobe & ~bus.bwr & w_inRange;
    assign w_wrCtrl  = w_wrStb & (w_offset[2:0] == 3'd0);
    assign w_wrTx    = w_wrStb & (w_offset[2:0] == 3'd1);
    assign w_rdRx    = w_rdStb & (w_offset[2:0] == 3'd2);
    assign w_wrFlags = w_wrStb & (w_offset[2:0] == 3'd4);

    assign w_txEmpty = (r_txCount == '0);
    assign w_txFull  = (r_txCount == FULL_COUNT);
    assign w_txPush  = w_wrTx & ~w_txFull;
    assign w_txPop   = r_enable & ~w_txEmpty & bus.tx_ready;
    assign w_txFlush = w_wrCtrl & bus.bwrdata[1];

    assign w_rxEmpty = (r_rxCount == '0);
    assign w_rxFull  = (r_rxCount == FULL_COUNT);
    assign w_rxPush  = r_enable & ~w_rxFull & bus.rx_valid;
    assign w_rxPop   = w_rdRx & ~w_rxEmpty;
    assign w_rxFlush = w_wrCtrl & bus.bwrdata[2];

    assign bus.tx_data  = r_txMem[r_txRp];
    assign bus.tx_valid = r_enable & ~w_txEmpty;
    assign bus.rx_ready = r_enable & ~w_rxFull;

    always_ff @(posedge clk) begin
        if (w_txPush) r_txMem[r_txWp] <= bus.bwrdata;
        if (w_rxPush) r_rxMem[r_rxWp] <= bus.rx_data;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_txWp    <= '0;
            r_txRp    <= '0;
            r_txCount <= '0;
        end else if (w_txFlush) begin
            r_txWp    <= '0;
            r_txRp    <= '0;
            r_txCount <= '0;
        end else begin
            if (w_txPush) r_txWp <= r_txWp + 1'b1;
            if (w_txPop)  r_txRp <= r_txRp + 1'b1;
            r_txCount <= r_txCount + CW'(w_txPush) - CW'(w_txPop);
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_rxWp    <= '0;
            r_rxRp    <= '0;
            r_rxCount <= '0;
        end else if (w_rxFlush) begin
            r_rxWp    <= '0;
            r_rxRp    <= '0;
            r_rxCount <= '0;
        end else begin
            if (w_rxPush) r_rxWp <= r_rxWp + 1'b1;
            if (w_rxPop)  r_rxRp <= r_rxRp + 1'b1;
            r_rxCount <= r_rxCount + CW'(w_rxPush) - CW'(w_rxPop);
        end
    end

    // Sticky error flags: a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_enable <= 1'b0;
            r_txOvf  <= 1'b0;
            r_rxUnf  <= 1'b0;
        end else begin
            if (w_wrCtrl) r_enable <= bus.bwrdata[0];
            if (w_wrTx & w_txFull)                    r_txOvf <= 1'b1;
            else if (w_wrFlags & bus.bwrdata[0])      r_txOvf <= 1'b0;
            if (w_rdRx & w_rxEmpty)                   r_rxUnf <= 1'b1;
            else if (w_wrFlags & bus.bwrdata[1])      r_rxUnf <= 1'b0;
        end
    end

    always_comb begin
        bus.brddata = 16'h0000;
        if (w_inRange) begin
            case (w_offset[2:0])
                3'd0: bus.brddata = {8'h00, r_rxUnf, r_txOvf, w_rxFull, w_rxEmpty,
                                     w_txFull, w_txEmpty, 1'b0, r_enable};
                3'd2: bus.brddata = w_rxEmpty ? 16'h0000 : r_rxMem[r_rxRp];
                3'd3: bus.brddata = {8'(r_rxCount), 8'(r_txCount)};
                3'd4: bus.brddata = {14'h0000, r_rxUnf, r_txOvf};
                default: bus.brddata = 16'h0000;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_stream_fifo.sv
// Directed self-checking bench for bus_stream_fifo (BASE_ADDR 16'h0040, depth 16).
module tb_bus_stream_fifo;
    logic clk;
    logic aresetn;
    int   checkCount;
    int   errorCount;

    bus_stream_fifo_if bif();

    bus_stream_fifo #(.BASE_ADDR(16'h0040), .DEPTH_LOG2(4)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge and are sampled 1ns later, well clear of the rising edge.
    task automatic busWrite(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bif.baddr = addr; bif.bwrdata = data; bif.bwr = 1'b1; bif.bstrobe = 1'b1;
        @(posedge clk);
        #1 bif.bstrobe = 1'b0; bif.bwr = 1'b0;
    endtask

    task automatic busRead(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        bif.baddr = addr; bif.bwr = 1'b0; bif.bstrobe = 1'b1;
        #1 data = bif.brddata;
        @(posedge clk);
        #1 bif.bstrobe = 1'b0;
    endtask

    task automatic peek(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        bif.baddr = addr;
        #1 data = bif.brddata;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        peek(16'h0000, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL reset_oor_rd got %h expected %h", d, 16'h0000); end
        checkCount++;
        if (bif.tx_valid !== 1'b0) begin errorCount++; $display("FAIL reset_tx_valid got %b expected 0", bif.tx_valid); end
        checkCount++;
        if (bif.rx_ready !== 1'b0) begin errorCount++; $display("FAIL reset_rx_ready got %b expected 0", bif.rx_ready); end
        aresetn = 1'b1;
        peek(16'h0040, d);
        checkCount++;
        if (d !== 16'h0014) begin errorCount++; $display("FAIL reset_status got %h expected %h", d, 16'h0014); end
        peek(16'h0045, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL oor_above got %h expected %h", d, 16'h0000); end
        peek(16'h003F, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL oor_below got %h expected %h", d, 16'h0000); end
    endtask

    task automatic test_tx_path;
        logic [15:0] d;
        busWrite(16'h0040, 16'h0001);
        busWrite(16'h0041, 16'hA5A5);
        busWrite(16'h0041, 16'h1234);
        @(negedge clk); #1;
        checkCount++;
        if (bif.tx_valid !== 1'b1 || bif.tx_data !== 16'hA5A5) begin
            errorCount++; $display("FAIL tx_first got v=%b %h expected v=1 %h", bif.tx_valid, bif.tx_data, 16'hA5A5);
        end
        bif.tx_ready = 1'b1;
        @(negedge clk); #1;
        checkCount++;
        if (bif.tx_valid !== 1'b1 || bif.tx_data !== 16'h1234) begin
            errorCount++; $display("FAIL tx_second got v=%b %h expected v=1 %h", bif.tx_valid, bif.tx_data, 16'h1234);
        end
        @(negedge clk); #1;
        bif.tx_ready = 1'b0;
        checkCount++;
        if (bif.tx_valid !== 1'b0) begin errorCount++; $display("FAIL tx_drained got %b expected 0", bif.tx_valid); end
        peek(16'h0041, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL txdata_rd got %h expected %h", d, 16'h0000); end
    endtask

    task automatic test_tx_overflow;
        logic [15:0] d;
        bif.tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) busWrite(16'h0041, 16'h0100 + 16'(i));
        peek(16'h0043, d);
        checkCount++;
        if (d !== 16'h0010) begin errorCount++; $display("FAIL ovf_counts got %h expected %h", d, 16'h0010); end
        peek(16'h0040, d);
        checkCount++;
        if (d !== 16'h0059) begin errorCount++; $display("FAIL ovf_status got %h expected %h", d, 16'h0059); end
        @(negedge clk);
        bif.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            checkCount++;
            if (bif.tx_valid !== 1'b1 || bif.tx_data !== 16'h0100 + 16'(i)) begin
                errorCount++;
                $display("FAIL ovf_drain[%0d] got v=%b %h expected v=1 %h", i, bif.tx_valid, bif.tx_data, 16'h0100 + 16'(i));
            end
        end
        @(negedge clk); #1;
        bif.tx_ready = 1'b0;
        checkCount++;
        if (bif.tx_valid !== 1'b0) begin errorCount++; $display("FAIL ovf_17th_absent got %b expected 0", bif.tx_valid); end
        busWrite(16'h0044, 16'h0001);
        peek(16'h0044, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL ovf_clear got %h expected %h", d, 16'h0000); end
    endtask

    task automatic test_rx_path;
        logic [15:0] d;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            bif.rx_valid = 1'b1; bif.rx_data = 16'(i);
        end
        @(negedge clk);
        bif.rx_valid = 1'b0;
        peek(16'h0043, d);
        checkCount++;
        if (d !== 16'h0300) begin errorCount++; $display("FAIL rx_counts got %h expected %h", d, 16'h0300); end
        for (int i = 1; i <= 4; i++) begin
            busRead(16'h0042, d);
            checkCount++;
            if (d !== ((i == 4) ? 16'h0000 : 16'(i))) begin
                errorCount++; $display("FAIL rx_read[%0d] got %h expected %h", i, d, (i == 4) ? 16'h0000 : 16'(i));
            end
        end
        peek(16'h0044, d);
        checkCount++;
        if (d !== 16'h0002) begin errorCount++; $display("FAIL rx_unf got %h expected %h", d, 16'h0002); end
        busWrite(16'h0044, 16'h0002);
        peek(16'h0044, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL rx_unf_clear got %h expected %h", d, 16'h0000); end
    endtask

    task automatic test_concurrency;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bif.rx_valid = 1'b1; bif.rx_data = 16'h0200 + 16'(i);
        end
        @(negedge clk);
        bif.rx_valid = 1'b0;
        peek(16'h0043, d);
        checkCount++;
        if (d !== 16'h1000 || bif.rx_ready !== 1'b0) begin
            errorCount++; $display("FAIL rx_full got %h rdy=%b expected %h rdy=0", d, bif.rx_ready, 16'h1000);
        end
        // Read of a full FIFO with a word offered in the same cycle.
        @(negedge clk);
        bif.rx_valid = 1'b1; bif.rx_data = 16'h02FF;
        bif.baddr = 16'h0042; bif.bwr = 1'b0; bif.bstrobe = 1'b1;
        #1;
        checkCount++;
        if (bif.rx_ready !== 1'b0 || bif.brddata !== 16'h0200) begin
            errorCount++; $display("FAIL conc_cycle got rdy=%b %h expected rdy=0 %h", bif.rx_ready, bif.brddata, 16'h0200);
        end
        @(negedge clk);
        bif.bstrobe = 1'b0; bif.baddr = 16'h0043;
        #1;
        checkCount++;
        if (bif.rx_ready !== 1'b1 || bif.brddata !== 16'h0F00) begin
            errorCount++; $display("FAIL conc_next got rdy=%b %h expected rdy=1 %h", bif.rx_ready, bif.brddata, 16'h0F00);
        end
        @(negedge clk);
        bif.rx_valid = 1'b0;
        #1;
        checkCount++;
        if (bif.brddata !== 16'h1000) begin errorCount++; $display("FAIL conc_refill got %h expected %h", bif.brddata, 16'h1000); end
        for (int i = 1; i <= 16; i++) begin
            busRead(16'h0042, d);
            checkCount++;
            if (d !== ((i == 16) ? 16'h02FF : 16'h0200 + 16'(i))) begin
                errorCount++;
                $display("FAIL conc_order[%0d] got %h expected %h", i, d, (i == 16) ? 16'h02FF : 16'h0200 + 16'(i));
            end
        end
    endtask

    task automatic test_flush_reset;
        logic [15:0] d;
        bif.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) busWrite(16'h0041, 16'h0300 + 16'(i));
        peek(16'h0043, d);
        checkCount++;
        if (d !== 16'h0005) begin errorCount++; $display("FAIL flush_pre got %h expected %h", d, 16'h0005); end
        busWrite(16'h0040, 16'h0003);
        peek(16'h0043, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL tx_flush_count got %h expected %h", d, 16'h0000); end
        peek(16'h0040, d);
        checkCount++;
        if (d !== 16'h0015) begin errorCount++; $display("FAIL tx_flush_status got %h expected %h", d, 16'h0015); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bif.rx_valid = 1'b1; bif.rx_data = 16'h0400 + 16'(i);
        end
        @(negedge clk);
        bif.rx_valid = 1'b0;
        busWrite(16'h0040, 16'h0005);
        peek(16'h0043, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL rx_flush_count got %h expected %h", d, 16'h0000); end
        for (int i = 0; i < 3; i++) busWrite(16'h0041, 16'h0500 + 16'(i));
        @(negedge clk);
        bif.rx_valid = 1'b1; bif.rx_data = 16'h0600; bif.tx_ready = 1'b1;
        @(negedge clk);
        bif.rx_valid = 1'b0;
        #2 aresetn = 1'b0;
        #1;
        checkCount++;
        if (bif.tx_valid !== 1'b0 || bif.rx_ready !== 1'b0) begin
            errorCount++; $display("FAIL async_reset got v=%b rdy=%b expected 0 0", bif.tx_valid, bif.rx_ready);
        end
        #1 aresetn = 1'b1;
        bif.tx_ready = 1'b0;
        peek(16'h0040, d);
        checkCount++;
        if (d !== 16'h0014) begin errorCount++; $display("FAIL post_reset_status got %h expected %h", d, 16'h0014); end
        peek(16'h0043, d);
        checkCount++;
        if (d !== 16'h0000) begin errorCount++; $display("FAIL post_reset_counts got %h expected %h", d, 16'h0000); end
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        aresetn = 1'b0;
        bif.baddr = 16'h0000; bif.bwrdata = 16'h0000; bif.bwr = 1'b0; bif.bstrobe = 1'b0;
        bif.tx_ready = 1'b0; bif.rx_data = 16'h0000; bif.rx_valid = 1'b0;
        test_reset();
        test_tx_path();
        test_tx_overflow();
        test_rx_path();
        test_concurrency();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
